// File: rtl/key_evt_pkg.sv
//==============================================================================
// Module   : key_evt_pkg
// Brief    : Event codes and FSM state encoding for the key press classifier.
// Revision : 1.0
//==============================================================================
`default_nettype none

package key_evt_pkg;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SHORT  = 2'b01;
    localparam logic [1:0] EVT_LONG   = 2'b10;
    localparam logic [1:0] EVT_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_WAIT2     = 3'd2,
        S_PRESS2    = 3'd3,
        S_LONG_HOLD = 3'd4
    } key_state_t;

endpackage : key_evt_pkg

`default_nettype wire

// File: rtl/key_press_classifier.sv
//==============================================================================
// Module   : key_press_classifier
// Brief    : Classifies debounced key edges into short/long/double gestures,
//            with a hold level and auto-repeat strobe during long hold.
// Revision : 1.0
//==============================================================================
`default_nettype none

module key_press_classifier
    import key_evt_pkg::*;
#(
    parameter int LONG_CNT    = 50_000_000,
    parameter int DBL_GAP_CNT = 15_000_000,
    parameter int REPEAT_CNT  = 10_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       hold_active,
    output logic       repeat_pulse
);

    localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST    = CNT_W'(DBL_GAP_CNT - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_press_ev;
    logic             w_rel_ev;
    logic             w_event_valid_nxt;
    logic [1:0]       w_event_code_nxt;
    logic             w_repeat_nxt;
    logic             w_hold_nxt;

    assign w_press_ev = key_flag & ~key_state;
    assign w_rel_ev   = key_flag &  key_state;

    // Every state change clears the timer; staying put increments it.
    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer + CNT_W'(1);
        w_event_valid_nxt = 1'b0;
        w_event_code_nxt  = EVT_NONE;
        w_repeat_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (w_press_ev) begin
                    w_state_nxt = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (w_rel_ev) begin
                    w_state_nxt = S_WAIT2;
                    w_timer_nxt = '0;
                end else if (r_timer == C_LONG_LAST) begin
                    w_state_nxt       = S_LONG_HOLD;
                    w_timer_nxt       = '0;
                    w_event_valid_nxt = 1'b1;
                    w_event_code_nxt  = EVT_LONG;
                end
            end
            S_WAIT2: begin
                if (w_press_ev) begin
                    w_state_nxt = S_PRESS2;
                    w_timer_nxt = '0;
                end else if (r_timer == C_GAP_LAST) begin
                    w_state_nxt       = S_IDLE;
                    w_timer_nxt       = '0;
                    w_event_valid_nxt = 1'b1;
                    w_event_code_nxt  = EVT_SHORT;
                end
            end
            S_PRESS2: begin
                if (w_rel_ev) begin
                    w_state_nxt       = S_IDLE;
                    w_timer_nxt       = '0;
                    w_event_valid_nxt = 1'b1;
                    w_event_code_nxt  = EVT_DOUBLE;
                end else if (r_timer == C_LONG_LAST) begin
                    w_state_nxt       = S_LONG_HOLD;
                    w_timer_nxt       = '0;
                    w_event_valid_nxt = 1'b1;
                    w_event_code_nxt  = EVT_LONG;
                end
            end
            S_LONG_HOLD: begin
                // A release in the wrap cycle ends the hold without a repeat.
                if (w_rel_ev) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == C_REPEAT_LAST) begin
                    w_timer_nxt  = '0;
                    w_repeat_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign w_hold_nxt = (w_state_nxt == S_LONG_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            event_valid  <= 1'b0;
            event_code   <= EVT_NONE;
            hold_active  <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            event_valid  <= w_event_valid_nxt;
            event_code   <= w_event_code_nxt;
            hold_active  <= w_hold_nxt;
            repeat_pulse <= w_repeat_nxt;
        end
    end

endmodule : key_press_classifier

`default_nettype wire

// File: tb/tb_key_press_classifier.sv
//==============================================================================
// Module   : tb_key_press_classifier
// Brief    : Directed self-checking bench for key_press_classifier.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_key_press_classifier;

    logic       clk;
    logic       rst;
    logic       key_flag;
    logic       key_state;
    logic       event_valid;
    logic [1:0] event_code;
    logic       hold_active;
    logic       repeat_pulse;

    int total;
    int bad;

    key_press_classifier #(
        .LONG_CNT    (20),
        .DBL_GAP_CNT (10),
        .REPEAT_CNT  (5),
        .CNT_W       (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .event_valid  (event_valid),
        .event_code   (event_code),
        .hold_active  (hold_active),
        .repeat_pulse (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input int c, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input int c, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Cycle c begins at the current time; flags driven in cycle c are sampled
    // at its closing edge, outputs checked in cycle c are those registered at
    // its opening edge. Unused flag/event slots use cycle -1.
    task automatic run_scn(input string name, input int n,
                           input int f0c, input logic f0s, input int f1c, input logic f1s,
                           input int f2c, input logic f2s, input int f3c, input logic f3s,
                           input int ev_c, input logic [1:0] ev_code,
                           input int hold_lo, input int hold_hi,
                           input int rep0, input int rep1);
        logic       e_v;
        logic [1:0] e_code;
        for (int c = 0; c < n; c++) begin
            e_v    = (c == ev_c);
            e_code = e_v ? ev_code : 2'b00;
            chk1({name, ".valid"},  c, event_valid,  e_v);
            chk2({name, ".code"},   c, event_code,   e_code);
            chk1({name, ".hold"},   c, hold_active,  (c >= hold_lo) && (c <= hold_hi));
            chk1({name, ".repeat"}, c, repeat_pulse, (c == rep0) || (c == rep1));
            key_flag  = 1'b0;
            key_state = 1'b1;
            if (c == f0c) begin key_flag = 1'b1; key_state = f0s; end
            if (c == f1c) begin key_flag = 1'b1; key_state = f1s; end
            if (c == f2c) begin key_flag = 1'b1; key_state = f2s; end
            if (c == f3c) begin key_flag = 1'b1; key_state = f3s; end
            adv();
        end
        key_flag  = 1'b0;
        key_state = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        key_flag  = 1'b0;
        key_state = 1'b1;
        repeat (3) adv();
        chk1("reset.valid",  0, event_valid,  1'b0);
        chk2("reset.code",   0, event_code,   2'b00);
        chk1("reset.hold",   0, hold_active,  1'b0);
        chk1("reset.repeat", 0, repeat_pulse, 1'b0);
        rst = 1'b0;
        adv();

        // Short press: press 0, release 5 -> short at 16.
        run_scn("short", 30, 0, 1'b0, 5, 1'b1, -1, 1'b0, -1, 1'b0,
                16, 2'b01, 1, 0, -1, -1);

        // Long press with repeat: press 0, release 33.
        run_scn("long", 45, 0, 1'b0, 33, 1'b1, -1, 1'b0, -1, 1'b0,
                21, 2'b10, 21, 33, 26, 31);

        // Double click: press 0, release 3, press 8, release 11.
        run_scn("double", 40, 0, 1'b0, 3, 1'b1, 8, 1'b0, 11, 1'b1,
                12, 2'b11, 1, 0, -1, -1);

        // Release exactly at the long threshold beats the long event.
        run_scn("tieA", 40, 0, 1'b0, 20, 1'b1, -1, 1'b0, -1, 1'b0,
                31, 2'b01, 1, 0, -1, -1);

        // Second press exactly at the gap timeout beats the short event.
        run_scn("tieB", 35, 0, 1'b0, 3, 1'b1, 13, 1'b0, 15, 1'b1,
                16, 2'b11, 1, 0, -1, -1);

        // Reset during long hold: outputs drop without a clock edge.
        run_scn("rstpre", 25, 0, 1'b0, -1, 1'b0, -1, 1'b0, -1, 1'b0,
                21, 2'b10, 21, 99, -1, -1);
        chk1("rst.hold_before", 25, hold_active, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("rst.hold_async",   25, hold_active,  1'b0);
        chk1("rst.valid_async",  25, event_valid,  1'b0);
        chk2("rst.code_async",   25, event_code,   2'b00);
        chk1("rst.repeat_async", 25, repeat_pulse, 1'b0);
        adv();
        rst = 1'b0;
        adv();
        run_scn("rstrel", 20, 0, 1'b1, -1, 1'b0, -1, 1'b0, -1, 1'b0,
                -1, 2'b00, 1, 0, -1, -1);
        run_scn("rstpost", 30, 0, 1'b0, 5, 1'b1, -1, 1'b0, -1, 1'b0,
                16, 2'b01, 1, 0, -1, -1);

        // Spurious flags: release in idle, then duplicate press in PRESS1.
        run_scn("idlerel", 8, 0, 1'b1, -1, 1'b0, -1, 1'b0, -1, 1'b0,
                -1, 2'b00, 1, 0, -1, -1);
        run_scn("dup", 30, 0, 1'b0, 4, 1'b0, 6, 1'b1, -1, 1'b0,
                17, 2'b01, 1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_key_press_classifier

`default_nettype wire
